// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// Package: traffic_pkg
// Purpose: Shared definitions for the traffic intersection plant model.
//   - lane_state_e : per-lane FSM encoding (EMPTY / WAITING / DRAINING)
//   - ST1_BIT/ST2_BIT : bit positions of street 1 / street 2 in y1y2 and l1l2
//   - QW_DEF / DEPART_CYCLES_DEF : default queue width and departure period
// ----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    LANE_EMPTY    = 2'd0,  // no vehicles queued
    LANE_WAITING  = 2'd1,  // vehicles queued, light red (or conflict)
    LANE_DRAINING = 2'd2   // vehicles queued, light green, departures in progress
  } lane_state_e;

  localparam int ST1_BIT = 1;
  localparam int ST2_BIT = 0;

  localparam int QW_DEF            = 4;
  localparam int DEPART_CYCLES_DEF = 3;

endpackage : traffic_pkg

// File: rtl/traffic_lane.sv
// ----------------------------------------------------------------------------
// Module: traffic_lane
// Purpose: One street of the intersection plant: a saturating vehicle queue,
//   a departure timer that releases one vehicle every DEPART_CYCLES green
//   cycles, a sticky drop flag and (optionally) a departure counter.
// Configuration macro: TRAFFIC_MODEL_STATS_EN
//   defined   -> served_o counts departures (wraps at 16'hFFFF)
//   undefined -> served_o tied to zero
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   arr_i      in   one vehicle arrives this cycle
//   green_i    in   this lane's light is green
//   conflict_i in   both lights green this cycle (blocks departures)
//   occupied_o out  queue non-empty (sensor to controller)
//   q_o        out  current queue count
//   drop_o     out  sticky: an arrival was lost at a full queue
//   served_o   out  departure count
// ----------------------------------------------------------------------------
module traffic_lane
  import traffic_pkg::*;
#(
  parameter int QW            = QW_DEF,
  parameter int DEPART_CYCLES = DEPART_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr_i,
  input  logic          green_i,
  input  logic          conflict_i,
  output logic          occupied_o,
  output logic [QW-1:0] q_o,
  output logic          drop_o,
  output logic [15:0]   served_o
);

  // A one-cycle departure period still needs a 1-bit timer to keep widths legal.
  localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [QW-1:0] Q_MAX  = {QW{1'b1}};
  localparam logic [TW-1:0] T_LAST = TW'(DEPART_CYCLES - 1);

  lane_state_e   state_q, state_d;
  logic [QW-1:0] q_q, q_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          drop_q, drop_d;
  logic          draining;
  logic          depart;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    q_d     = q_q;
    drop_d  = drop_q;
    timer_d = '0;
    state_d = state_q;

    // Draining is judged on the light as sampled this cycle, so the first
    // green cycle already advances the timer.
    draining = (state_q != LANE_EMPTY) && green_i && !conflict_i;
    depart   = draining && (timer_q == T_LAST);

    if (draining) begin
      timer_d = depart ? '0 : timer_q + 1'b1;
    end

    // A departure and an arrival in the same cycle cancel, even at full.
    if (arr_i && !depart) begin
      if (q_q == Q_MAX) begin
        drop_d = 1'b1;
      end else begin
        q_d = q_q + 1'b1;
      end
    end else if (depart && !arr_i) begin
      q_d = q_q - 1'b1;
    end

    if (q_d == '0) begin
      state_d = LANE_EMPTY;
    end else if (green_i && !conflict_i) begin
      state_d = LANE_DRAINING;
    end else begin
      state_d = LANE_WAITING;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= LANE_EMPTY;
      q_q     <= '0;
      timer_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      timer_q <= timer_d;
      drop_q  <= drop_d;
    end
  end

  assign occupied_o = (q_q != '0);
  assign q_o        = q_q;
  assign drop_o     = drop_q;

`ifdef TRAFFIC_MODEL_STATS_EN
  logic [15:0] served_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      served_q <= '0;
    end else if (depart) begin
      served_q <= served_q + 16'd1;
    end
  end

  assign served_o = served_q;
`else
  assign served_o = 16'h0000;
`endif

endmodule : traffic_lane

// File: rtl/traffic_intersection_model.sv
// ----------------------------------------------------------------------------
// Module: traffic_intersection_model
// Purpose: Synthesizable plant model for the far end of a traffic light
//   controller. Consumes the controller's lights (y1y2) and produces its
//   sensor inputs (l1l2) from two vehicle queues fed by arrival pulses.
// Configuration macro: TRAFFIC_MODEL_STATS_EN (enables served1/served2)
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   arr1/arr2 in   vehicle arrival pulse, street 1 / street 2
//   y1y2      in   lights: [1]=street1 green, [0]=street2 green
//   l1l2      out  sensors: [1]=street1 occupied, [0]=street2 occupied
//   q1/q2     out  queue counts
//   drop      out  sticky lost-arrival flags, [1]=st1, [0]=st2
//   conflict  out  sticky: both lights green was observed
//   served1/2 out  departure counters (zero unless stats enabled)
// ----------------------------------------------------------------------------
module traffic_intersection_model
  import traffic_pkg::*;
#(
  parameter int QW            = QW_DEF,
  parameter int DEPART_CYCLES = DEPART_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr1,
  input  logic          arr2,
  input  logic [1:0]    y1y2,
  output logic [1:0]    l1l2,
  output logic [QW-1:0] q1,
  output logic [QW-1:0] q2,
  output logic [1:0]    drop,
  output logic          conflict,
  output logic [15:0]   served1,
  output logic [15:0]   served2
);

  logic conflict_now;
  logic conflict_q;

  // Lights are used exactly as sampled; the controller shares this clock.
  assign conflict_now = (y1y2 == 2'b11);

  traffic_lane #(
    .QW            (QW),
    .DEPART_CYCLES (DEPART_CYCLES)
  ) u_lane1 (
    .clk        (clk),
    .reset      (reset),
    .arr_i      (arr1),
    .green_i    (y1y2[ST1_BIT]),
    .conflict_i (conflict_now),
    .occupied_o (l1l2[ST1_BIT]),
    .q_o        (q1),
    .drop_o     (drop[ST1_BIT]),
    .served_o   (served1)
  );

  traffic_lane #(
    .QW            (QW),
    .DEPART_CYCLES (DEPART_CYCLES)
  ) u_lane2 (
    .clk        (clk),
    .reset      (reset),
    .arr_i      (arr2),
    .green_i    (y1y2[ST2_BIT]),
    .conflict_i (conflict_now),
    .occupied_o (l1l2[ST2_BIT]),
    .q_o        (q2),
    .drop_o     (drop[ST2_BIT]),
    .served_o   (served2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= 1'b0;
    end else if (conflict_now) begin
      conflict_q <= 1'b1;
    end
  end

  assign conflict = conflict_q;

endmodule : traffic_intersection_model

// File: tb/tb_traffic_intersection_model.sv
// ----------------------------------------------------------------------------
// Testbench: tb_traffic_intersection_model
// Directed scenarios followed by a randomized phase, all checked every cycle
// against a queue-level reference model (integer queues and timers).
// ----------------------------------------------------------------------------
module tb_traffic_intersection_model;

  localparam int QW   = 4;
  localparam int DC   = 3;
  localparam int QMAX = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          arr1, arr2;
  logic [1:0]    y1y2;
  logic [1:0]    l1l2;
  logic [QW-1:0] q1, q2;
  logic [1:0]    drop;
  logic          conflict;
  logic [15:0]   served1, served2;

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = street 1 (light bit 1), index 1 = street 2 (bit 0).
  int         mq[2];
  int         mt[2];
  int         mserved[2];
  logic [1:0] mdrop;
  logic       mconf;

  traffic_intersection_model #(
    .QW            (QW),
    .DEPART_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .arr1     (arr1),
    .arr2     (arr2),
    .y1y2     (y1y2),
    .l1l2     (l1l2),
    .q1       (q1),
    .q2       (q2),
    .drop     (drop),
    .conflict (conflict),
    .served1  (served1),
    .served2  (served2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic a1, input logic a2, input logic [1:0] y, input logic rst);
    logic arr[2];
    int   light_bit;
    logic dep;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mq[i] = 0; mt[i] = 0; mserved[i] = 0;
      end
      mdrop = 2'b00;
      mconf = 1'b0;
    end else begin
      arr[0] = a1;
      arr[1] = a2;
      for (int i = 0; i < 2; i++) begin
        light_bit = (i == 0) ? 1 : 0;
        dep = 1'b0;
        if (mq[i] > 0 && y[light_bit] && y != 2'b11) begin
          mt[i]++;
          if (mt[i] == DC) begin
            dep   = 1'b1;
            mt[i] = 0;
          end
        end else begin
          mt[i] = 0;
        end
        if (arr[i] && !dep) begin
          if (mq[i] == QMAX) mdrop[light_bit] = 1'b1;
          else mq[i]++;
        end else if (dep && !arr[i]) begin
          mq[i]--;
        end
        if (dep) mserved[i] = (mserved[i] + 1) % 65536;
      end
      if (y == 2'b11) mconf = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("q1", 32'(q1), 32'(mq[0]));
    chk("q2", 32'(q2), 32'(mq[1]));
    chk("l1l2", 32'(l1l2), {30'd0, mq[0] != 0, mq[1] != 0});
    chk("drop", 32'(drop), 32'(mdrop));
    chk("conflict", 32'(conflict), 32'(mconf));
`ifdef TRAFFIC_MODEL_STATS_EN
    chk("served1", 32'(served1), 32'(mserved[0]));
    chk("served2", 32'(served2), 32'(mserved[1]));
`else
    chk("served1", 32'(served1), 32'd0);
    chk("served2", 32'(served2), 32'd0);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then sample #1 after the edge.
  task automatic step(input logic a1, input logic a2, input logic [1:0] y, input logic rst);
    arr1  = a1;
    arr2  = a2;
    y1y2  = y;
    reset = rst;
    model_step(a1, a2, y, rst);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    arr1  = 1'b0;
    arr2  = 1'b0;
    y1y2  = 2'b00;
    model_step(1'b0, 1'b0, 2'b00, 1'b1);

    // 1. Reset dominates arrivals.
    repeat (5) step(1'b1, 1'b1, 2'b00, 1'b1);
    chk("rst_q1", 32'(q1), 32'd0);
    chk("rst_l1l2", 32'(l1l2), 32'd0);

    // 2. Three arrivals on street 1 under red, then hold.
    repeat (3) step(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (20) step(1'b0, 1'b0, 2'b00, 1'b0);
    chk("hold_q1", 32'(q1), 32'd3);
    chk("hold_l1l2", 32'(l1l2), 32'b10);

    // 3. Green on street 1 drains one vehicle every DC cycles.
    repeat (8) step(1'b0, 1'b0, 2'b10, 1'b0);
    chk("drain_q1_before_last", 32'(q1), 32'd1);
    step(1'b0, 1'b0, 2'b10, 1'b0);
    chk("drain_q1", 32'(q1), 32'd0);
    chk("drain_l1l2", 32'(l1l2), 32'd0);

    // 4. Overfill street 2, then reset clears the drop flag.
    repeat (16) step(1'b0, 1'b1, 2'b00, 1'b0);
    chk("full_q2", 32'(q2), 32'd15);
    chk("full_drop", 32'(drop), 32'b01);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("clr_q2", 32'(q2), 32'd0);
    chk("clr_drop", 32'(drop), 32'b00);

    // 5. Conflict blocks departures and is sticky.
    repeat (2) step(1'b1, 1'b1, 2'b00, 1'b0);
    repeat (10) step(1'b0, 1'b0, 2'b11, 1'b0);
    chk("conf_q1", 32'(q1), 32'd2);
    chk("conf_q2", 32'(q2), 32'd2);
    step(1'b0, 1'b0, 2'b00, 1'b0);
    chk("conf_sticky", 32'(conflict), 32'd1);

    // 6. Arrival on every departure cycle keeps q1 constant; reset mid-timer.
    step(1'b0, 1'b0, 2'b00, 1'b1);
    repeat (2) step(1'b1, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 9; k++) step((k % DC) == DC - 1, 1'b0, 2'b10, 1'b0);
    chk("simul_q1", 32'(q1), 32'd2);
    step(1'b0, 1'b0, 2'b10, 1'b0);
    step(1'b0, 1'b0, 2'b10, 1'b1);
    step(1'b1, 1'b0, 2'b10, 1'b0);
    repeat (2) step(1'b0, 1'b0, 2'b10, 1'b0);
    chk("restart_q1_held", 32'(q1), 32'd1);
    step(1'b0, 1'b0, 2'b10, 1'b0);
    chk("restart_q1_gone", 32'(q1), 32'd0);

    // Randomized phase: biased arrivals, light patterns, occasional reset.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40,
           2'($urandom_range(0, 3)), $urandom_range(0, 99) < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_traffic_intersection_model
